// File: rtl/sram_tp_be_wr_packer.sv
// Write-side packer for the two-port bit-enable SRAM.
// Collects COL_WD-bit columns from a valid/ready stream into DAT_WD-bit
// words and issues one SRAM write per completed (or final partial) word,
// with per-column write enables covering unaligned first and last words.
module sram_tp_be_wr_packer #(
  parameter  int ADR_WD  = 5,
  parameter  int DAT_WD  = 64,
  parameter  int COL_WD  = 8,
  parameter  int LEN_WD  = 16,
  localparam int COL_NUM = DAT_WD / COL_WD,
  localparam int CNT_WD  = $clog2(DAT_WD / COL_WD)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [ADR_WD-1:0]  base_adr_i,
  input  logic [CNT_WD-1:0]  start_col_i,
  input  logic [LEN_WD-1:0]  len_i,
  input  logic               in_val_i,
  input  logic [COL_WD-1:0]  in_dat_i,
  output logic               in_rdy_o,
  output logic [COL_NUM-1:0] wr_ena_o,
  output logic [ADR_WD-1:0]  wr_adr_o,
  output logic [DAT_WD-1:0]  wr_dat_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt;

  logic [ADR_WD-1:0]   adr_r;
  logic [CNT_WD-1:0]   col_r;
  logic [LEN_WD-1:0]   rem_r;
  logic [COL_NUM-1:0]  pk_ena_r;
  logic [DAT_WD-1:0]   pk_dat_r;

  logic [COL_NUM-1:0]  wr_ena_r;
  logic [ADR_WD-1:0]   wr_adr_r;
  logic [DAT_WD-1:0]   wr_dat_r;
  logic                done_r;

  logic                beat_acc;
  logic                beat_last;
  logic                beat_flush;
  logic [COL_NUM-1:0]  beat_ena;
  logic [DAT_WD-1:0]   beat_dat;

  assign beat_acc   = (state_r == BUSY) && in_val_i;
  assign beat_last  = (rem_r == LEN_WD'(1));
  assign beat_flush = (col_r == CNT_WD'(COL_NUM - 1)) || beat_last;

  // Steer the incoming column into its lane of a word-wide vector.
  always_comb begin
    beat_ena = '0;
    beat_dat = '0;
    for (int unsigned c = 0; c < COL_NUM; c++) begin
      if (col_r == CNT_WD'(c)) begin
        beat_ena[c]                  = 1'b1;
        beat_dat[c*COL_WD +: COL_WD] = in_dat_i;
      end
    end
  end

  // Next-state logic: a zero-length start never leaves IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start_i && (len_i != '0)) state_nxt = BUSY;
      BUSY:    if (beat_acc && beat_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // Transfer bookkeeping, packing and the registered SRAM write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adr_r    <= '0;
      col_r    <= '0;
      rem_r    <= '0;
      pk_ena_r <= '0;
      pk_dat_r <= '0;
      wr_ena_r <= '0;
      wr_adr_r <= '0;
      wr_dat_r <= '0;
      done_r   <= 1'b0;
    end else begin
      wr_ena_r <= '0;
      done_r   <= 1'b0;
      if ((state_r == IDLE) && start_i) begin
        adr_r    <= base_adr_i;
        col_r    <= start_col_i;
        rem_r    <= len_i;
        pk_ena_r <= '0;
        pk_dat_r <= '0;
        if (len_i == '0) done_r <= 1'b1;
      end else if (beat_acc) begin
        rem_r <= rem_r - LEN_WD'(1);
        col_r <= col_r + CNT_WD'(1);
        if (beat_flush) begin
          // Merge the completing beat directly into the write; pack regs restart empty.
          wr_ena_r <= pk_ena_r | beat_ena;
          wr_dat_r <= pk_dat_r | beat_dat;
          wr_adr_r <= adr_r;
          adr_r    <= adr_r + ADR_WD'(1);
          pk_ena_r <= '0;
          pk_dat_r <= '0;
        end else begin
          pk_ena_r <= pk_ena_r | beat_ena;
          pk_dat_r <= pk_dat_r | beat_dat;
        end
        if (beat_last) done_r <= 1'b1;
      end
    end
  end

  assign in_rdy_o = (state_r == BUSY);
  assign busy_o   = (state_r == BUSY);
  assign wr_ena_o = wr_ena_r;
  assign wr_adr_o = wr_adr_r;
  assign wr_dat_o = wr_dat_r;
  assign done_o   = done_r;

endmodule

// File: tb/tb_sram_tp_be_wr_packer.sv
// Self-checking bench for sram_tp_be_wr_packer (default parameters).
// Expected SRAM writes are queued as each scenario drives its stimulus and
// a negedge monitor pops and compares every write the DUT issues.
module tb_sram_tp_be_wr_packer;

  localparam int ADR_WD  = 5;
  localparam int DAT_WD  = 64;
  localparam int COL_WD  = 8;
  localparam int LEN_WD  = 16;
  localparam int COL_NUM = 8;
  localparam int CNT_WD  = 3;

  typedef struct packed {
    logic [ADR_WD-1:0]  adr;
    logic [COL_NUM-1:0] ena;
    logic [DAT_WD-1:0]  dat;
  } wr_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start_i = 1'b0;
  logic [ADR_WD-1:0]  base_adr_i = '0;
  logic [CNT_WD-1:0]  start_col_i = '0;
  logic [LEN_WD-1:0]  len_i = '0;
  logic               in_val_i = 1'b0;
  logic [COL_WD-1:0]  in_dat_i = '0;
  logic               in_rdy_o;
  logic [COL_NUM-1:0] wr_ena_o;
  logic [ADR_WD-1:0]  wr_adr_o;
  logic [DAT_WD-1:0]  wr_dat_o;
  logic               busy_o;
  logic               done_o;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  sram_tp_be_wr_packer #(
    .ADR_WD(ADR_WD),
    .DAT_WD(DAT_WD),
    .COL_WD(COL_WD),
    .LEN_WD(LEN_WD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .base_adr_i (base_adr_i),
    .start_col_i(start_col_i),
    .len_i      (len_i),
    .in_val_i   (in_val_i),
    .in_dat_i   (in_dat_i),
    .in_rdy_o   (in_rdy_o),
    .wr_ena_o   (wr_ena_o),
    .wr_adr_o   (wr_adr_o),
    .wr_dat_o   (wr_dat_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every nonzero write must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && (wr_ena_o != '0)) begin
      wr_t got;
      wr_t exp;
      got = '{adr: wr_adr_o, ena: wr_ena_o, dat: wr_dat_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got adr=%0d ena=%h dat=%h, required no write", got.adr, got.ena, got.dat);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL write: got adr=%0d ena=%h dat=%h, required adr=%0d ena=%h dat=%h",
                   got.adr, got.ena, got.dat, exp.adr, exp.ena, exp.dat);
        end
      end
    end
  end

  task automatic push_exp(input logic [ADR_WD-1:0] adr, input logic [COL_NUM-1:0] ena,
                          input logic [DAT_WD-1:0] dat);
    exp_q.push_back('{adr: adr, ena: ena, dat: dat});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADR_WD-1:0] adr, input logic [CNT_WD-1:0] col,
                          input logic [LEN_WD-1:0] len);
    start_i     = 1'b1;
    base_adr_i  = adr;
    start_col_i = col;
    len_i       = len;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic send_beat(input logic [COL_WD-1:0] d);
    in_val_i = 1'b1;
    in_dat_i = d;
    tick();
    in_val_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b, required 0", in_rdy_o); end
    if (wr_ena_o !== '0)   begin n_fail++; $display("FAIL reset_wr_ena: got %h, required 0", wr_ena_o); end
    if (wr_adr_o !== '0)   begin n_fail++; $display("FAIL reset_wr_adr: got %h, required 0", wr_adr_o); end
    if (wr_dat_o !== '0)   begin n_fail++; $display("FAIL reset_wr_dat: got %h, required 0", wr_dat_o); end
    if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    if (done_o !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b, required 0", done_o); end
  endtask

  task automatic run_aligned(input string name);
    push_exp(5'd3, 8'hFF, 64'h0706050403020100);
    push_exp(5'd4, 8'hFF, 64'h0F0E0D0C0B0A0908);
    do_start(5'd3, 3'd0, 16'd16);
    n_checks += 2;
    if (busy_o !== 1'b1)   begin n_fail++; $display("FAIL %s_busy: got %b, required 1", name, busy_o); end
    if (in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL %s_rdy: got %b, required 1", name, in_rdy_o); end
    for (int i = 0; i < 16; i++) send_beat(8'(i));
    n_checks += 2;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b, required 1", name, done_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b, required 0", name, busy_o); end
    tick();
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b, required 0", name, done_o); end
    drain(name);
  endtask

  task automatic test_aligned();
    run_aligned("aligned");
  endtask

  task automatic test_unaligned();
    push_exp(5'd0, 8'hE0, 64'hA2A1A00000000000);
    push_exp(5'd1, 8'h03, 64'h000000000000A4A3);
    do_start(5'd0, 3'd5, 16'd5);
    for (int i = 0; i < 5; i++) send_beat(8'hA0 + 8'(i));
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL unaligned_done: got %b, required 1", done_o); end
    drain("unaligned");
  endtask

  task automatic test_wrap_gaps();
    logic [COL_WD-1:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    push_exp(5'd31, 8'hC0, 64'h2211000000000000);
    push_exp(5'd0,  8'h03, 64'h0000000000004433);
    do_start(5'd31, 3'd6, 16'd4);
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i]);
      if (i < 3) begin
        tick();
        n_checks++;
        if (wr_ena_o !== '0) begin n_fail++; $display("FAIL gap_no_write: got ena=%h, required 0", wr_ena_o); end
      end
    end
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b, required 1", done_o); end
    drain("wrap");
    n_checks++;
    if (wr_adr_o !== 5'd0) begin n_fail++; $display("FAIL wrap_adr_hold: got %0d, required 0", wr_adr_o); end
  endtask

  task automatic test_len0_busy_start();
    do_start(5'd7, 3'd0, 16'd0);
    n_checks += 2;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b, required 1", done_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b, required 0", busy_o); end
    tick();
    tick();
    push_exp(5'd10, 8'hFF, 64'h5756555453525150);
    do_start(5'd10, 3'd0, 16'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start_i = 1'b1; base_adr_i = 5'd20; start_col_i = 3'd2; len_i = 16'd2;
      end
      send_beat(8'h50 + 8'(i));
      start_i = 1'b0;
      if (i == 3) begin
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: got %b, required 1", busy_o); end
      end
    end
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL busy_start_done: got %b, required 1", done_o); end
    drain("busy_start");
  endtask

  task automatic test_reset_mid();
    do_start(5'd5, 3'd0, 16'd8);
    for (int i = 0; i < 3; i++) send_beat(8'hE0 + 8'(i));
    in_val_i = 1'b1;
    #2 rstn = 1'b0;
    #1;
    n_checks += 4;
    if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy_o); end
    if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: got %b, required 0", in_rdy_o); end
    if (wr_ena_o !== '0 || wr_adr_o !== '0 || wr_dat_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_wr: got ena=%h adr=%h dat=%h, required all 0", wr_ena_o, wr_adr_o, wr_dat_o);
    end
    if (done_o !== 1'b0)   begin n_fail++; $display("FAIL rstmid_done: got %b, required 0", done_o); end
    in_val_i = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    run_aligned("after_reset");
  endtask

  task automatic test_back_to_back();
    push_exp(5'd2, 8'hF0, 64'hB3B2B1B000000000);
    push_exp(5'd8, 8'h07, 64'h0000000000C2C1C0);
    do_start(5'd2, 3'd4, 16'd4);
    for (int i = 0; i < 4; i++) send_beat(8'hB0 + 8'(i));
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b, required 1", done_o); end
    do_start(5'd8, 3'd0, 16'd3);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, required 1", busy_o); end
    for (int i = 0; i < 3; i++) send_beat(8'hC0 + 8'(i));
    drain("b2b");
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    test_aligned();
    test_unaligned();
    test_wrap_gaps();
    test_len0_busy_start();
    test_reset_mid();
    test_back_to_back();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
